ddr3_user_port_arbiter: RTL and testbench
=========================================

# ddr3_user_port_arbiter

Round-robin request scheduler that lets up to NUM_REQ independent requesters share the single user port (write_enable/read_enable, i_user_data_address, i_user_data, o_user_data) of ddr3_memory_controller. It sits between the FPGA-internal clients (loopback tester, DMA, debug) and the controller. It accepts one command at a time and drives the controller's enables until the command is acknowledged. It returns read data or write completion tagged with the requester ID, and it times out reads that never return.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDRESS_BITWIDTH, 15, DDR row/column address width
- BANK_ADDRESS_BITWIDTH, 3, bank address width
- DQ_BITWIDTH, 16, user data width
- RD_TIMEOUT, 1023, maximum cycles to wait for read data after ack
- Derived: AW = BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH; IW = max(1,$clog2(NUM_REQ))

Ports:
- clk  in  1  single clock for all logic
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*AW  flattened addresses; requester i at [i*AW +: AW]
- req_wdata  in  NUM_REQ*DQ_BITWIDTH  flattened write data
- write_enable  out  1  to controller
- read_enable  out  1  to controller
- i_user_data_address  out  AW  to controller
- i_user_data  out  DQ_BITWIDTH  to controller
- ctrl_ack  in  1  controller has taken the current command
- ctrl_rdata_valid  in  1  o_user_data is valid this cycle
- o_user_data  in  DQ_BITWIDTH  read data from controller
- rsp_valid  out  1  one-cycle completion pulse
- rsp_id  out  IW  requester index of the completion
- rsp_write  out  1  1 = write completion, 0 = read
- rsp_data  out  DQ_BITWIDTH  captured read data; 0 for writes
- rsp_timeout  out  1  set together with rsp_valid when a read timed out
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT_RDATA.
- **IDLE:**
  - Search from pointer rr_ptr upward with wrap for the first set req_valid bit. The winner is g.
  - req_ready is combinational: bit g high only in IDLE; all zeros otherwise or when no requests are pending.
  - On acceptance (req_valid[g] & req_ready[g]):
    - Latch the command (write flag, address, wdata; wdata latched as 0 for reads) and the ID g.
    - Set rr_ptr = (g+1) mod NUM_REQ.
    - Go to ISSUE.
- **ISSUE:**
  - Assert write_enable (write) or read_enable (read) from registers.
  - Hold i_user_data_address and i_user_data stable.
  - On ctrl_ack, write command: drop the enable, pulse rsp_valid with rsp_write=1 and rsp_data=0, go to IDLE.
  - On ctrl_ack, read command: drop the enable, clear the timeout counter, go to WAIT_RDATA.
  - On ctrl_ack with ctrl_rdata_valid in the same cycle for a read: complete immediately. Capture o_user_data, pulse rsp_valid, go to IDLE.
- **WAIT_RDATA:**
  - The counter increments each cycle.
  - On ctrl_rdata_valid: rsp_data = o_user_data, rsp_write=0, pulse rsp_valid, go to IDLE.
  - When the counter reaches RD_TIMEOUT without data: pulse rsp_valid with rsp_timeout=1 and rsp_data=0, go to IDLE.
  - ctrl_rdata_valid on the timeout cycle wins: it is a normal completion with no timeout.
- ctrl_rdata_valid outside a pending read is ignored.
- Requests are never dropped. A requester holds req_valid and its command fields until req_ready is seen.
- Counter width is $clog2(RD_TIMEOUT+1) and the counter saturates. rr_ptr width is IW, and the wrap is explicit for non-power-of-2 NUM_REQ.

## Timing
- Reset values (async, resetn=0):
  - state = IDLE, rr_ptr = 0.
  - write_enable, read_enable, rsp_valid, rsp_write and rsp_timeout are 0.
  - Address, data, rsp_data and rsp_id are 0. busy = 0.
- Reset mid-command: the enables drop immediately (asynchronously). The pending command is lost and no response is issued.
- Acceptance in cycle T: the enable is high from T+1. Earliest ack is sampled at T+1, and the enable is low at T+2.
- Write completion: rsp_valid is high in the cycle after ctrl_ack is sampled, coincident with the enable going low.
- Read completion: rsp_valid is high the cycle after ctrl_rdata_valid is sampled.
- Throughput:
  - Back-to-back writes with immediate ack: one command per 2 cycles, since IDLE must be revisited.
  - The next acceptance can occur in the same cycle rsp_valid is high.
- rsp_valid is a single-cycle pulse. rsp_id, rsp_write, rsp_data and rsp_timeout are valid only while rsp_valid is high and are held otherwise.

## Test plan
- **Single write:**
  - Stimulus: after reset, req0 writes addr 0x00005, data 0x00AB; ctrl_ack tied high.
  - Required: write_enable high for exactly 1 cycle with those values, then rsp_valid with rsp_id=0, rsp_write=1.
- **Round robin:**
  - Stimulus: req_valid=4'b1111 held continuously; each requester drops its valid for one cycle after being accepted and then reasserts; ack immediate.
  - Required: grant order 0,1,2,3,0,1.
  - Required: with only req1 and req3 valid, order 1,3,1,3.
- **Read with latency:**
  - Stimulus: req2 reads addr 0x00004; ack at T+3; ctrl_rdata_valid with o_user_data=0x0004 five cycles later.
  - Required: read_enable held through the ack; rsp_valid rsp_id=2, rsp_write=0, rsp_data=0x0004, rsp_timeout=0.
  - Required: req_ready is all zeros throughout.
- **Read timeout:**
  - Stimulus: RD_TIMEOUT=8; read acked but no data returned.
  - Required: rsp_valid with rsp_timeout=1, rsp_data=0 exactly 8 cycles after entering WAIT_RDATA.
  - Required: a late ctrl_rdata_valid afterwards produces no response.
- **Same-cycle ack and data:**
  - Stimulus: ctrl_ack and ctrl_rdata_valid asserted together for a read.
  - Required: a single response carrying that data, and the block is back in IDLE next cycle.
- **Reset mid-read:**
  - Stimulus: resetn low while in WAIT_RDATA.
  - Required: all outputs are at reset values within the same cycle, rr_ptr=0, and no rsp_valid pulse.

Source files
------------

// File: rtl/ddr3_user_port_arbiter.sv
// Round-robin scheduler sharing the ddr3_memory_controller user port among NUM_REQ clients.
// Issues one command at a time and returns tagged write completions, read data or read timeouts.
module ddr3_user_port_arbiter #(
    parameter int NUM_REQ               = 4,
    parameter int ADDRESS_BITWIDTH      = 15,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int DQ_BITWIDTH           = 16,
    parameter int RD_TIMEOUT            = 1023,
    localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH,
    localparam int IW = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW = $clog2(RD_TIMEOUT + 1)
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*AW-1:0]          req_addr,
    input  logic [NUM_REQ*DQ_BITWIDTH-1:0] req_wdata,
    output logic                           write_enable,
    output logic                           read_enable,
    output logic [AW-1:0]                  i_user_data_address,
    output logic [DQ_BITWIDTH-1:0]         i_user_data,
    input  logic                           ctrl_ack,
    input  logic                           ctrl_rdata_valid,
    input  logic [DQ_BITWIDTH-1:0]         o_user_data,
    output logic                           rsp_valid,
    output logic [IW-1:0]                  rsp_id,
    output logic                           rsp_write,
    output logic [DQ_BITWIDTH-1:0]         rsp_data,
    output logic                           rsp_timeout,
    output logic                           busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RDATA} state_t;

    state_t                 state_q;
    logic [IW-1:0]          rr_ptr_q;
    logic [IW-1:0]          rr_ptr_d;
    logic                   cmd_write_q;
    logic [IW-1:0]          cmd_id_q;
    logic [AW-1:0]          addr_q;
    logic [DQ_BITWIDTH-1:0] wdata_q;
    logic                   wr_en_q;
    logic                   rd_en_q;
    logic                   rsp_valid_q;
    logic [IW-1:0]          rsp_id_q;
    logic                   rsp_write_q;
    logic [DQ_BITWIDTH-1:0] rsp_data_q;
    logic                   rsp_timeout_q;
    logic [CW-1:0]          rd_cnt_q;
    logic [CW-1:0]          rd_cnt_d;

    logic                   grant_found;
    logic [IW-1:0]          grant_idx;
    logic [IW:0]            scan_wide;
    logic                   sel_write;
    logic [AW-1:0]          sel_addr;
    logic [DQ_BITWIDTH-1:0] sel_wdata;
    logic                   accept;

    // Scan upward from rr_ptr with explicit wrap so non-power-of-2 NUM_REQ works.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_wide   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_wide = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (scan_wide >= (IW+1)'(NUM_REQ)) begin
                scan_wide = scan_wide - (IW+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[scan_wide[IW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_wide[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IW'(k) == grant_idx) begin
                sel_write = req_write[k];
                sel_addr  = req_addr[k*AW +: AW];
                sel_wdata = req_wdata[k*DQ_BITWIDTH +: DQ_BITWIDTH];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept   = (state_q == IDLE) && grant_found;
    assign rr_ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
    assign rd_cnt_d = (rd_cnt_q == CW'(RD_TIMEOUT)) ? rd_cnt_q : rd_cnt_q + CW'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            cmd_write_q   <= 1'b0;
            cmd_id_q      <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_write_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            rd_cnt_q      <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cmd_write_q <= sel_write;
                        cmd_id_q    <= grant_idx;
                        addr_q      <= sel_addr;
                        wdata_q     <= sel_write ? sel_wdata : '0;
                        wr_en_q     <= sel_write;
                        rd_en_q     <= !sel_write;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ctrl_ack) begin
                        wr_en_q <= 1'b0;
                        rd_en_q <= 1'b0;
                        if (cmd_write_q) begin
                            rsp_valid_q   <= 1'b1;
                            rsp_id_q      <= cmd_id_q;
                            rsp_write_q   <= 1'b1;
                            rsp_data_q    <= '0;
                            rsp_timeout_q <= 1'b0;
                            state_q       <= IDLE;
                        end else if (ctrl_rdata_valid) begin
                            rsp_valid_q   <= 1'b1;
                            rsp_id_q      <= cmd_id_q;
                            rsp_write_q   <= 1'b0;
                            rsp_data_q    <= o_user_data;
                            rsp_timeout_q <= 1'b0;
                            state_q       <= IDLE;
                        end else begin
                            rd_cnt_q <= '0;
                            state_q  <= WAIT_RDATA;
                        end
                    end
                end
                WAIT_RDATA: begin
                    // Data arriving on the timeout cycle still counts as a normal completion.
                    if (ctrl_rdata_valid) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_id_q      <= cmd_id_q;
                        rsp_write_q   <= 1'b0;
                        rsp_data_q    <= o_user_data;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= IDLE;
                    end else if (rd_cnt_d == CW'(RD_TIMEOUT)) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_id_q      <= cmd_id_q;
                        rsp_write_q   <= 1'b0;
                        rsp_data_q    <= '0;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        rd_cnt_q <= rd_cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign write_enable        = wr_en_q;
    assign read_enable         = rd_en_q;
    assign i_user_data_address = addr_q;
    assign i_user_data         = wdata_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_id              = rsp_id_q;
    assign rsp_write           = rsp_write_q;
    assign rsp_data            = rsp_data_q;
    assign rsp_timeout         = rsp_timeout_q;
    assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_ddr3_user_port_arbiter.sv
// Directed bench for ddr3_user_port_arbiter; responses are checked by a scoreboard monitor
// against expectations queued when each command is issued.
module tb_ddr3_user_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ABW     = 15;
    localparam int BBW     = 3;
    localparam int DQ      = 16;
    localparam int RD_TO   = 8;
    localparam int AW      = ABW + BBW;
    localparam int IW      = 2;

    logic                  clk;
    logic                  resetn;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DQ-1:0] req_wdata;
    logic                  write_enable;
    logic                  read_enable;
    logic [AW-1:0]         i_user_data_address;
    logic [DQ-1:0]         i_user_data;
    logic                  ctrl_ack;
    logic                  ctrl_rdata_valid;
    logic [DQ-1:0]         o_user_data;
    logic                  rsp_valid;
    logic [IW-1:0]         rsp_id;
    logic                  rsp_write;
    logic [DQ-1:0]         rsp_data;
    logic                  rsp_timeout;
    logic                  busy;

    ddr3_user_port_arbiter #(
        .NUM_REQ              (NUM_REQ),
        .ADDRESS_BITWIDTH     (ABW),
        .BANK_ADDRESS_BITWIDTH(BBW),
        .DQ_BITWIDTH          (DQ),
        .RD_TIMEOUT           (RD_TO)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_write          (req_write),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .write_enable       (write_enable),
        .read_enable        (read_enable),
        .i_user_data_address(i_user_data_address),
        .i_user_data        (i_user_data),
        .ctrl_ack           (ctrl_ack),
        .ctrl_rdata_valid   (ctrl_rdata_valid),
        .o_user_data        (o_user_data),
        .rsp_valid          (rsp_valid),
        .rsp_id             (rsp_id),
        .rsp_write          (rsp_write),
        .rsp_data           (rsp_data),
        .rsp_timeout        (rsp_timeout),
        .busy               (busy)
    );

    typedef struct {
        logic [IW-1:0] id;
        logic          wr;
        logic [DQ-1:0] data;
        logic          to;
    } rsp_t;

    rsp_t sbQueue[$];
    int   checkCount = 0;
    int   passCount  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic pushExpected(input int id, input logic wr, input logic [DQ-1:0] data, input logic to);
        rsp_t e;
        e.id   = IW'(id);
        e.wr   = wr;
        e.data = data;
        e.to   = to;
        sbQueue.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        req_valid        = '0;
        req_write        = '0;
        req_addr         = '0;
        req_wdata        = '0;
        ctrl_ack         = 1'b0;
        ctrl_rdata_valid = 1'b0;
        o_user_data      = '0;
    endtask

    task automatic applyStimulus(input int id, input logic wr, input logic [AW-1:0] addr, input logic [DQ-1:0] data);
        req_valid[id]          = 1'b1;
        req_write[id]          = wr;
        req_addr[id*AW +: AW]  = addr;
        req_wdata[id*DQ +: DQ] = data;
    endtask

    task automatic applyReset();
        clearInputs();
        resetn = 1'b0;
        nextCycle();
        nextCycle();
        resetn = 1'b1;
    endtask

    // Each accepted requester drops valid for one cycle and then re-requests a write.
    task automatic runGrantSequence(input logic [NUM_REQ-1:0] mask, input logic [15:0] expIds, input int n);
        logic [NUM_REQ-1:0] r;
        int grants;
        int g;
        grants = 0;
        ctrl_ack = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) applyStimulus(k, 1'b1, AW'(k), DQ'(16'h1000 + k));
        req_valid = mask;
        for (int c = 0; c < 40 && grants < n; c++) begin
            @(negedge clk);
            r = req_ready;
            if (r != '0) begin
                g = 0;
                for (int k = 0; k < NUM_REQ; k++) if (r[k]) g = k;
                checkOutput("rr grant order", g, {30'd0, expIds[grants*2 +: 2]});
                pushExpected(g, 1'b1, '0, 1'b0);
                grants++;
            end
            nextCycle();
            req_valid = mask & ~r;
        end
        req_valid = '0;
        checkOutput("rr grant count", grants, n);
        repeat (3) nextCycle();
        ctrl_ack = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        rsp_t e;
        if (resetn && rsp_valid) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected rsp_valid", 32'd1, 32'd0);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("rsp_id", rsp_id, e.id);
                checkOutput("rsp_write", rsp_write, e.wr);
                checkOutput("rsp_data", rsp_data, e.data);
                checkOutput("rsp_timeout", rsp_timeout, e.to);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearInputs();
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("reset write_enable", write_enable, 0);
        checkOutput("reset read_enable", read_enable, 0);
        checkOutput("reset rsp_valid", rsp_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset address", i_user_data_address, 0);
        checkOutput("reset wdata", i_user_data, 0);
        checkOutput("reset rsp fields", {rsp_id, rsp_write, rsp_data, rsp_timeout}, 0);
        nextCycle();
        resetn = 1'b1;

        // Single write with ack tied high
        ctrl_ack = 1'b1;
        applyStimulus(0, 1'b1, 18'h00005, 16'h00AB);
        @(negedge clk);
        checkOutput("write ready", req_ready, 4'b0001);
        pushExpected(0, 1'b1, '0, 1'b0);
        nextCycle();
        req_valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("write_enable on", write_enable, 1);
        checkOutput("write no read_enable", read_enable, 0);
        checkOutput("write address", i_user_data_address, 18'h00005);
        checkOutput("write data", i_user_data, 16'h00AB);
        checkOutput("write busy", busy, 1);
        checkOutput("write ready blocked", req_ready, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("write_enable one cycle", write_enable, 0);
        checkOutput("write back idle", busy, 0);
        nextCycle();
        ctrl_ack = 1'b0;

        // Read with ack at T+3 and data five cycles later; req0 waits meanwhile
        applyStimulus(2, 1'b0, 18'h00004, '0);
        @(negedge clk);
        checkOutput("read ready", req_ready, 4'b0100);
        pushExpected(2, 1'b0, 16'h0004, 1'b0);
        nextCycle();
        req_valid[2] = 1'b0;
        applyStimulus(0, 1'b1, 18'h00010, 16'h55AA);
        for (int c = 1; c <= 8; c++) begin
            if (c == 3) ctrl_ack = 1'b1;
            if (c == 8) begin
                ctrl_rdata_valid = 1'b1;
                o_user_data      = 16'h0004;
            end
            @(negedge clk);
            checkOutput("read ready zero", req_ready, 0);
            checkOutput("read_enable level", read_enable, (c <= 3) ? 1 : 0);
            if (c == 1) checkOutput("read address", i_user_data_address, 18'h00004);
            nextCycle();
            ctrl_ack         = 1'b0;
            ctrl_rdata_valid = 1'b0;
            o_user_data      = '0;
        end
        @(negedge clk);
        checkOutput("pending write granted", req_ready, 4'b0001);
        pushExpected(0, 1'b1, '0, 1'b0);
        nextCycle();
        req_valid[0] = 1'b0;
        ctrl_ack     = 1'b1;
        @(negedge clk);
        checkOutput("second write_enable", write_enable, 1);
        checkOutput("second write data", i_user_data, 16'h55AA);
        nextCycle();
        ctrl_ack = 1'b0;

        // Ack and read data in the same cycle
        applyStimulus(3, 1'b0, 18'h00007, '0);
        @(negedge clk);
        checkOutput("same-cycle ready", req_ready, 4'b1000);
        pushExpected(3, 1'b0, 16'hBEEF, 1'b0);
        nextCycle();
        req_valid[3]     = 1'b0;
        ctrl_ack         = 1'b1;
        ctrl_rdata_valid = 1'b1;
        o_user_data      = 16'hBEEF;
        @(negedge clk);
        checkOutput("same-cycle read_enable", read_enable, 1);
        nextCycle();
        ctrl_ack         = 1'b0;
        ctrl_rdata_valid = 1'b0;
        o_user_data      = '0;
        @(negedge clk);
        checkOutput("same-cycle idle", busy, 0);
        checkOutput("same-cycle read_enable off", read_enable, 0);
        nextCycle();

        // Read timeout: data never comes back, then a late strobe
        applyStimulus(1, 1'b0, 18'h00123, '0);
        @(negedge clk);
        checkOutput("timeout ready", req_ready, 4'b0010);
        pushExpected(1, 1'b0, '0, 1'b1);
        nextCycle();
        req_valid[1] = 1'b0;
        ctrl_ack     = 1'b1;
        nextCycle();
        ctrl_ack = 1'b0;
        for (int c = 0; c < RD_TO; c++) begin
            @(negedge clk);
            checkOutput("no early timeout", rsp_valid, 0);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("timeout pulse", rsp_valid, 1);
        checkOutput("timeout flag", rsp_timeout, 1);
        nextCycle();
        ctrl_rdata_valid = 1'b1;
        o_user_data      = 16'h9999;
        @(negedge clk);
        checkOutput("after timeout idle", busy, 0);
        nextCycle();
        ctrl_rdata_valid = 1'b0;
        o_user_data      = '0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("late data ignored", rsp_valid, 0);
            nextCycle();
        end

        // Reset while waiting for read data
        applyStimulus(2, 1'b0, 18'h00042, '0);
        @(negedge clk);
        checkOutput("reset-read ready", req_ready, 4'b0100);
        nextCycle();
        req_valid[2] = 1'b0;
        ctrl_ack     = 1'b1;
        nextCycle();
        ctrl_ack = 1'b0;
        #2;
        checkOutput("wait state busy", busy, 1);
        resetn = 1'b0;
        #1;
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset address", i_user_data_address, 0);
        checkOutput("async reset enables", {write_enable, read_enable}, 0);
        checkOutput("async reset rsp_valid", rsp_valid, 0);
        nextCycle();
        nextCycle();
        resetn = 1'b1;
        repeat (RD_TO + 2) begin
            @(negedge clk);
            checkOutput("no rsp after reset", rsp_valid, 0);
            nextCycle();
        end

        runGrantSequence(4'b1111, {4'd0, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}, 6);
        applyReset();
        runGrantSequence(4'b1010, {8'd0, 2'd3, 2'd1, 2'd3, 2'd1}, 4);

        checkOutput("scoreboard drained", sbQueue.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
